// File: rtl/tlul_arb2.sv
// Two-requester TL-UL arbiter in front of a single shared LED slave.
// Only one transaction is outstanding at a time. Ties in IDLE go to the
// requester that was not granted last. Illegal opcodes are answered locally
// with an error response, and the slave never sees them.
module tlul_arb2 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    // requester 0
    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [ADDR_W-1:0] m0_a_address,
    input  logic [DATA_W-1:0] m0_a_data,
    output logic              m0_d_valid,
    input  logic              m0_d_ready,
    output logic [2:0]        m0_d_opcode,
    output logic [DATA_W-1:0] m0_d_data,
    output logic              m0_d_error,
    // requester 1
    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [ADDR_W-1:0] m1_a_address,
    input  logic [DATA_W-1:0] m1_a_data,
    output logic              m1_d_valid,
    input  logic              m1_d_ready,
    output logic [2:0]        m1_d_opcode,
    output logic [DATA_W-1:0] m1_d_data,
    output logic              m1_d_error,
    // shared slave
    output logic              s_a_valid,
    input  logic              s_a_ready,
    output logic [2:0]        s_a_opcode,
    output logic [ADDR_W-1:0] s_a_address,
    output logic [DATA_W-1:0] s_a_data,
    input  logic              s_d_valid,
    output logic              s_d_ready,
    input  logic [2:0]        s_d_opcode,
    input  logic [DATA_W-1:0] s_d_data,
    input  logic              s_d_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // PutFullData (0), PutPartialData (1) and Get (4) are the only opcodes forwarded
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            3'd0:    legal = 1'b1;
            3'd1:    legal = 1'b1;
            3'd4:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e              state_q;
    logic                last_grant_q;   // 1: m1 was granted last
    logic                winner_q;       // requester owning the current transaction
    logic [2:0]          opcode_q;
    logic [ADDR_W-1:0]   address_q;
    logic [DATA_W-1:0]   data_q;

    logic                grant_vld_s;
    logic                grant_id_s;
    logic [2:0]          sel_opcode_s;
    logic [ADDR_W-1:0]   sel_address_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                win_d_ready_s;
    state_e              state_s;
    logic                rsp_valid_s;
    logic [2:0]          rsp_opcode_s;
    logic [DATA_W-1:0]   rsp_data_s;
    logic                rsp_error_s;

    // While reset is held, every output decodes as an idle arbiter with no grant.
    assign state_s       = i_reset_n ? state_q : ST_IDLE;
    assign grant_vld_s   = (m0_a_valid | m1_a_valid) & i_reset_n;
    assign grant_id_s    = (m0_a_valid & m1_a_valid) ? ~last_grant_q : m1_a_valid;
    assign sel_opcode_s  = grant_id_s ? m1_a_opcode  : m0_a_opcode;
    assign sel_address_s = grant_id_s ? m1_a_address : m0_a_address;
    assign sel_data_s    = grant_id_s ? m1_a_data    : m0_a_data;
    assign win_d_ready_s = winner_q ? m1_d_ready : m0_d_ready;

    // Transaction FSM: capture the winner in IDLE, forward to the slave, return the response
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            opcode_q     <= 3'd0;
            address_q    <= '0;
            data_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        winner_q  <= grant_id_s;
                        opcode_q  <= sel_opcode_s;
                        address_q <= sel_address_s;
                        data_q    <= sel_data_s;
                        state_q   <= is_legal_op(sel_opcode_s) ? ST_REQ : ST_ERR;
                    end
                end
                ST_REQ: begin
                    if (s_a_ready) begin
                        state_q <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (s_d_valid && win_d_ready_s) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= winner_q;
                    end
                end
                ST_ERR: begin
                    if (win_d_ready_s) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= winner_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode: only the signals owned by the current state are non-zero
    always_comb begin
        m0_a_ready   = 1'b0;
        m1_a_ready   = 1'b0;
        s_a_valid    = 1'b0;
        s_a_opcode   = 3'd0;
        s_a_address  = '0;
        s_a_data     = '0;
        s_d_ready    = 1'b0;
        rsp_valid_s  = 1'b0;
        rsp_opcode_s = 3'd0;
        rsp_data_s   = '0;
        rsp_error_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                m0_a_ready = grant_vld_s & ~grant_id_s;
                m1_a_ready = grant_vld_s & grant_id_s;
            end
            ST_REQ: begin
                s_a_valid   = 1'b1;
                s_a_opcode  = opcode_q;
                s_a_address = address_q;
                s_a_data    = data_q;
            end
            ST_RSP: begin
                s_d_ready    = win_d_ready_s;
                rsp_valid_s  = s_d_valid;
                rsp_opcode_s = s_d_opcode;
                rsp_data_s   = s_d_data;
                rsp_error_s  = s_d_error;
            end
            ST_ERR: begin
                rsp_valid_s = 1'b1;
                rsp_error_s = 1'b1;
            end
            default: begin
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // Steer the response to the winner; the other requester sees all zeros
    assign m0_d_valid  = rsp_valid_s & ~winner_q;
    assign m0_d_opcode = winner_q ? 3'd0 : rsp_opcode_s;
    assign m0_d_data   = winner_q ? '0   : rsp_data_s;
    assign m0_d_error  = rsp_error_s & ~winner_q;
    assign m1_d_valid  = rsp_valid_s & winner_q;
    assign m1_d_opcode = winner_q ? rsp_opcode_s : 3'd0;
    assign m1_d_data   = winner_q ? rsp_data_s   : '0;
    assign m1_d_error  = rsp_error_s & winner_q;

endmodule

// File: tb/tb_tlul_arb2.sv
// Directed bench for tlul_arb2: reset, put/get flows, fairness, error path,
// slave and requester back-pressure, and reset in the middle of a response.
module tb_tlul_arb2;

    logic       i_clk;
    logic       i_reset_n;
    logic       m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready, m0_d_error;
    logic [2:0] m0_a_opcode, m0_d_opcode;
    logic [7:0] m0_a_address, m0_a_data, m0_d_data;
    logic       m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready, m1_d_error;
    logic [2:0] m1_a_opcode, m1_d_opcode;
    logic [7:0] m1_a_address, m1_a_data, m1_d_data;
    logic       s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error;
    logic [2:0] s_a_opcode, s_d_opcode;
    logic [7:0] s_a_address, s_a_data, s_d_data;

    int tests = 0;
    int fails = 0;

    tlul_arb2 #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_address(m0_a_address), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_data(m0_d_data), .m0_d_error(m0_d_error),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_address(m1_a_address), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_data(m1_d_data), .m1_d_error(m1_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_address(s_a_address), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_data(s_d_data), .s_d_error(s_d_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        m0_a_valid = 1'b1; m0_a_opcode = 3'd0; m0_a_address = 8'h00; m0_a_data = 8'hA5; m0_d_ready = 1'b0;
        m1_a_valid = 1'b0; m1_a_opcode = 3'd0; m1_a_address = 8'h00; m1_a_data = 8'h00; m1_d_ready = 1'b0;
        s_a_ready = 1'b0; s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_data = 8'h00; s_d_error = 1'b0;
        #12;
        // reset: outputs quiet even with inputs active
        chk("rst_m0_a_ready", 32'(m0_a_ready), 32'd0);
        chk("rst_s_a_valid", 32'(s_a_valid), 32'd0);
        chk("rst_s_d_ready", 32'(s_d_ready), 32'd0);
        chk("rst_m0_d_valid", 32'(m0_d_valid), 32'd0);
        s_d_valid = 1'b0;
        i_reset_n = 1'b1;
        #1;
        // basic put from m0
        chk("put_m0_a_ready", 32'(m0_a_ready), 32'd1);
        chk("put_m1_a_ready", 32'(m1_a_ready), 32'd0);
        chk("put_idle_s_a_valid", 32'(s_a_valid), 32'd0);
        tick();
        m0_a_valid = 1'b0; s_a_ready = 1'b1;
        #1;
        chk("put_s_a_valid", 32'(s_a_valid), 32'd1);
        chk("put_s_a_data", 32'(s_a_data), 32'hA5);
        chk("put_s_a_opcode", 32'(s_a_opcode), 32'd0);
        tick();
        s_a_ready = 1'b0; s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_data = 8'h00; m0_d_ready = 1'b1;
        #1;
        chk("put_m0_d_valid", 32'(m0_d_valid), 32'd1);
        chk("put_m0_d_error", 32'(m0_d_error), 32'd0);
        chk("put_m1_d_valid", 32'(m1_d_valid), 32'd0);
        chk("put_s_d_ready", 32'(s_d_ready), 32'd1);
        tick();
        s_d_valid = 1'b0;
        #1;
        chk("put_done_m0_d_valid", 32'(m0_d_valid), 32'd0);

        // fairness from a fresh reset: m0, m1, m0, m1
        i_reset_n = 1'b0;
        #1;
        i_reset_n = 1'b1;
        m0_a_valid = 1'b1; m0_a_opcode = 3'd0; m0_a_address = 8'h10; m0_a_data = 8'h11;
        m1_a_valid = 1'b1; m1_a_opcode = 3'd4; m1_a_address = 8'h20; m1_a_data = 8'h22;
        m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fair_m0_a_ready", 32'(m0_a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("fair_m1_a_ready", 32'(m1_a_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            s_a_ready = 1'b1;
            #1;
            chk("fair_s_a_address", 32'(s_a_address), (k % 2 == 0) ? 32'h10 : 32'h20);
            tick();
            s_a_ready = 1'b0; s_d_valid = 1'b1; s_d_data = 8'h5A;
            #1;
            chk("fair_rsp_m1_a_ready", 32'(m1_a_ready), 32'd0);
            tick();
            s_d_valid = 1'b0;
        end
        m0_a_valid = 1'b0; m1_a_valid = 1'b0; m1_d_ready = 1'b0;

        // illegal opcode from m1 is answered locally
        m1_a_valid = 1'b1; m1_a_opcode = 3'd7; m1_a_address = 8'h40; m1_a_data = 8'h99;
        #1;
        chk("err_m1_a_ready", 32'(m1_a_ready), 32'd1);
        tick();
        m1_a_valid = 1'b0; s_d_valid = 1'b1; s_d_data = 8'hEE;
        #1;
        chk("err_s_a_valid", 32'(s_a_valid), 32'd0);
        chk("err_m1_d_valid", 32'(m1_d_valid), 32'd1);
        chk("err_m1_d_error", 32'(m1_d_error), 32'd1);
        chk("err_m1_d_data", 32'(m1_d_data), 32'd0);
        chk("err_m1_d_opcode", 32'(m1_d_opcode), 32'd0);
        chk("err_m0_d_valid", 32'(m0_d_valid), 32'd0);
        chk("err_s_d_ready", 32'(s_d_ready), 32'd0);
        tick();
        chk("err_hold_m1_d_valid", 32'(m1_d_valid), 32'd1);
        m1_d_ready = 1'b1;
        tick();
        s_d_valid = 1'b0; m1_d_ready = 1'b0;
        #1;
        chk("err_done_m1_d_valid", 32'(m1_d_valid), 32'd0);

        // slave stall: m1 granted last, so m0 wins the tie
        m0_a_valid = 1'b1; m0_a_opcode = 3'd1; m0_a_address = 8'h55; m0_a_data = 8'h77;
        m1_a_valid = 1'b1; m1_a_opcode = 3'd0; m1_a_address = 8'h66; m1_a_data = 8'h88;
        #1;
        chk("stall_m0_a_ready", 32'(m0_a_ready), 32'd1);
        tick();
        m0_a_opcode = 3'd0; m0_a_address = 8'hFF; m0_a_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_s_a_valid", 32'(s_a_valid), 32'd1);
            chk("stall_s_a_payload", {8'd0, 5'(s_a_opcode), s_a_address, s_a_data}, 32'h00015577);
            chk("stall_a_ready", {30'd0, m0_a_ready, m1_a_ready}, 32'd0);
            tick();
        end
        m0_a_valid = 1'b0; s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0; s_d_valid = 1'b1; m0_d_ready = 1'b1;
        #1;
        chk("stall_rsp_m1_a_ready", 32'(m1_a_ready), 32'd0);
        tick();
        s_d_valid = 1'b0;
        #1;
        chk("after_rsp_m1_a_ready", 32'(m1_a_ready), 32'd1);
        m1_a_valid = 1'b0;
        tick();
        chk("drop_s_a_valid", 32'(s_a_valid), 32'd0);
        chk("drop_m1_d_valid", 32'(m1_d_valid), 32'd0);

        // get with requester back-pressure on D
        m0_a_valid = 1'b1; m0_a_opcode = 3'd4; m0_a_address = 8'h03; m0_a_data = 8'h00; m0_d_ready = 1'b0;
        tick();
        m0_a_valid = 1'b0; s_a_ready = 1'b1;
        #1;
        chk("get_s_a_opcode", 32'(s_a_opcode), 32'd4);
        tick();
        s_a_ready = 1'b0; s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_data = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("get_bp_s_d_ready", 32'(s_d_ready), 32'd0);
            chk("get_bp_m0_d", {20'd0, 1'(m0_d_valid), 3'(m0_d_opcode), m0_d_data}, 32'h0000093C);
            tick();
        end
        m0_d_ready = 1'b1;
        #1;
        chk("get_s_d_ready", 32'(s_d_ready), 32'd1);
        tick();
        chk("get_done_m0_d_valid", 32'(m0_d_valid), 32'd0);
        chk("get_idle_s_d_ready", 32'(s_d_ready), 32'd0);
        s_d_valid = 1'b0;

        // reset pulsed while in RSP
        m0_a_valid = 1'b1; m0_a_opcode = 3'd4; m0_a_address = 8'h08; m0_d_ready = 1'b0;
        tick();
        m0_a_valid = 1'b0; s_a_ready = 1'b1;
        tick();
        s_a_ready = 1'b0; s_d_valid = 1'b1; s_d_data = 8'h12;
        #1;
        chk("rsp_pre_rst_m0_d_valid", 32'(m0_d_valid), 32'd1);
        i_reset_n = 1'b0;
        #1;
        chk("rsp_rst_m0_d_valid", 32'(m0_d_valid), 32'd0);
        chk("rsp_rst_s_d_ready", 32'(s_d_ready), 32'd0);
        tick();
        i_reset_n = 1'b1;
        m1_a_valid = 1'b1; m1_a_opcode = 3'd4; m1_a_address = 8'h2B;
        #1;
        chk("post_rst_m1_a_ready", 32'(m1_a_ready), 32'd1);
        chk("post_rst_s_d_ready", 32'(s_d_ready), 32'd0);
        chk("post_rst_m0_d_valid", 32'(m0_d_valid), 32'd0);
        tick();
        m1_a_valid = 1'b0;
        #1;
        chk("post_rst_s_a_valid", 32'(s_a_valid), 32'd1);
        chk("post_rst_s_a_address", 32'(s_a_address), 32'h2B);
        s_d_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
